// File: rtl/cdm_error_monitor.sv
// Error-distance monitor for an approximate multiplier under test.
// Accumulates sum/max/count of |a*b - r_approx| over a run of num_samples accepted samples.
module cdm_error_monitor #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic [2*W-1:0]         r_approx,
  output logic                   busy,
  output logic                   done,
  output logic [2*W+CNT_W-1:0]   sum_ed,
  output logic [2*W-1:0]         max_ed,
  output logic [CNT_W-1:0]       err_count
);

  localparam int unsigned P_W = 2 * W;
  localparam int unsigned S_W = 2 * W + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             run_start;
  logic             accept;
  logic             enter_done;

  logic [CNT_W-1:0] n_target;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_cnt_inc;

  logic             s1_valid;
  logic [P_W-1:0]   s1_exact;
  logic [P_W-1:0]   s1_r;
  logic [P_W-1:0]   ed;

  assign acc_cnt_inc = acc_cnt + CNT_W'(1);

  // Error distance of the sample currently held in stage 1
  assign ed = (s1_exact >= s1_r) ? (s1_exact - s1_r) : (s1_r - s1_exact);

  // Next-state and control decode
  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    accept     = 1'b0;
    enter_done = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          run_start = 1'b1;
          if (num_samples == '0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        accept = in_valid && in_ready;
        if (accept && (acc_cnt_inc == n_target)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Stay until stage 2 has absorbed the last sample
        if (!s1_valid) begin
          state_next = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == RUN);
      busy     <= (state_next == RUN) || (state_next == DRAIN);
      done     <= enter_done;
    end
  end

  // Run length latch and accept counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_target <= '0;
      acc_cnt  <= '0;
    end else if (run_start) begin
      n_target <= num_samples;
      acc_cnt  <= '0;
    end else if (accept) begin
      acc_cnt  <= acc_cnt_inc;
    end
  end

  // Stage 1: exact product and approximate product capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exact <= '0;
      s1_r     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact <= P_W'(a) * P_W'(b);
        s1_r     <= r_approx;
      end
    end
  end

  // Stage 2: statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed    <= '0;
      max_ed    <= '0;
      err_count <= '0;
    end else if (run_start) begin
      sum_ed    <= '0;
      max_ed    <= '0;
      err_count <= '0;
    end else if (s1_valid) begin
      sum_ed    <= sum_ed + S_W'(ed);
      if (ed > max_ed) begin
        max_ed  <= ed;
      end
      err_count <= err_count + CNT_W'(ed != '0);
    end
  end

endmodule

// File: doc/cdm_error_monitor.md
CDM_ERROR_MONITOR -- requirements
Module: cdm_error_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  W      16  operand width
  CNT_W  20  sample-counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk          input   1           single clock, rising edge
  rst_n        input   1           asynchronous active-low reset
  start        input   1           begin a measurement run
  num_samples  input   CNT_W       samples in run, sampled on accepted start
  in_valid     input   1           sample present on a/b/r_approx
  in_ready     output  1           monitor accepts a sample
  a            input   W           multiplier operand A
  b            input   W           multiplier operand B
  r_approx     input   2W          approximate product R from the multiplier under test
  busy         output  1           run in progress
  done         output  1           one-cycle completion pulse
  sum_ed       output  2W+CNT_W    sum of error distances |A*B - R|
  max_ed       output  2W          largest error distance in run
  err_count    output  CNT_W       samples with nonzero error distance
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-005 IDLE: start=1 SHALL latch num_samples, clear sum_ed/max_ed/err_count and the accept counter, and move to RUN; if num_samples=0, it SHALL move to DONE instead.
REQ-006 start SHALL be ignored in RUN and DRAIN; start in DONE SHALL behave as in IDLE.
REQ-007 in_ready SHALL be 1 only in RUN; a sample SHALL be accepted on an edge where in_valid=1 and in_ready=1.
REQ-008 Idle cycles on in_valid SHALL be tolerated without limit and SHALL NOT affect results.
REQ-009 When the accept count reaches num_samples, the block SHALL move from RUN to DRAIN on that same edge.
REQ-010 Stage 1 SHALL register exact = a*b (2W-bit unsigned) and r_approx on the accepting edge.
REQ-011 Stage 2 SHALL compute ed = |exact - r_approx| on the next edge (unsigned, 2W bits), then update the statistics:
  sum_ed += ed
  max_ed = max(max_ed, ed)
  err_count += (ed != 0)
REQ-012 sum_ed SHALL be wide enough that no overflow occurs for any num_samples < 2^CNT_W, so no saturation is needed.
REQ-013 DRAIN SHALL last until stage 2 has absorbed the last sample; the block SHALL then enter DONE at the second edge after the last accepting edge.
REQ-014 done SHALL be 1 for exactly the first cycle in DONE; the statistics SHALL be final in that cycle and SHALL be held until the next accepted start.
REQ-015 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-016 For num_samples=0, done SHALL pulse in the cycle after the start edge, with all statistics at 0.
REQ-017 Throughput SHALL be one sample per cycle, with no bubbles when in_valid is held at 1.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE and clear the pipeline: in_ready=0, busy=0, done=0, sum_ed=0, max_ed=0, err_count=0.
REQ-019 Reset mid-run SHALL discard all partial results; the next run SHALL need a new start.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
  V1 num_samples=1; a=3, b=5, r_approx=15 -> done 2 edges after accept; sum_ed=0, max_ed=0, err_count=0.
  V2 num_samples=2; (0xFFFF,0xFFFF,R=0) then (2,2,R=3) -> sum_ed=4294836226, max_ed=0xFFFE0001, err_count=2.
  V3 num_samples=4, in_valid toggling 1,0,0,1,1,0,1; samples (10,10,R=96) x4 -> sum_ed=16, err_count=4, in_ready falls after the 4th accept.
  V4 num_samples=0 -> done one cycle after start; all statistics 0; busy never 1.
  V5 start pulsed during RUN of num_samples=3 -> ignored; exactly 3 samples accepted.
  V6 rst_n low after 2 of 5 accepts -> all outputs 0 immediately; a new start with num_samples=1 gives correct results.
